// File: rtl/wb_mem_tester.sv
// wb_mem_tester: fills NUM_WORDS words starting at BASE_ADDR with a pattern over a pipelined Wishbone master,
//   reads them back in order and counts words whose read data differs from the regenerated expectation.
// Latency: stb/cyc rise the cycle after start; the run takes at least 2*NUM_WORDS cycles plus drain of each phase.
// Backpressure: requests hold on m_wb_stall; stb drops while MAX_OUTSTANDING requests are unacknowledged.
// Ports: clk/aresetn; start/seed control; busy/done/pass/err_count/first_err_addr status; m_wb_* master bus.
// Option: define WB_MEM_TESTER_LFSR_EN to replace the (index XOR seed) pattern with a Galois LFSR sequence.
module wb_mem_tester #(
    parameter int ADDR_BITS       = 23,
    parameter int DATA_BYTES      = 2,
    parameter int NUM_WORDS       = 1024,
    parameter int BASE_ADDR       = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [DATA_BYTES*8-1:0] seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [31:0]             err_count,
    output logic [ADDR_BITS-1:0]    first_err_addr,
    output logic [ADDR_BITS-1:0]    m_wb_addr,
    output logic [DATA_BYTES*8-1:0] m_wb_dat_m2s,
    input  logic [DATA_BYTES*8-1:0] m_wb_dat_s2m,
    output logic                    m_wb_we,
    output logic [DATA_BYTES-1:0]   m_wb_sel,
    output logic                    m_wb_stb,
    output logic                    m_wb_cyc,
    input  logic                    m_wb_ack,
    input  logic                    m_wb_stall
);

    localparam int                   DW       = DATA_BYTES * 8;
    localparam logic [ADDR_BITS-1:0] BASE     = ADDR_BITS'(BASE_ADDR);
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_WORDS - 1);
    localparam logic [3:0]           MAX_OUT  = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {IDLE, WRITE, WAIT_WR, READ, WAIT_RD, DONE} state_t;

    state_t               state_q, state_d;
    logic                 cyc_q, cyc_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;          // index of the next request to issue
    logic [3:0]           outst_q, outst_d;
    logic [DW-1:0]        seed_q, seed_d;
    logic [ADDR_BITS-1:0] chk_idx_q, chk_idx_d;  // index of the next read ack to check
    logic [31:0]          err_q, err_d;
    logic [ADDR_BITS-1:0] first_err_q, first_err_d;
    logic [1:0]           rst_sync_q;

    logic                 issuing, accept, ack_vld, rd_ack, last_acc, start_ok;
    logic [DW-1:0]        exp_word;

`ifdef WB_MEM_TESTER_LFSR_EN
    // Right-shifting Galois masks; maximal length for 8/16/24/32/64-bit data, other widths reuse the 16-bit mask.
    localparam logic [63:0] TAPS64 = (DW == 8)  ? 64'hB8 :
                                     (DW == 16) ? 64'hB400 :
                                     (DW == 24) ? 64'hE1_0000 :
                                     (DW == 32) ? 64'h8020_0003 :
                                     (DW == 64) ? 64'hD800_0000_0000_0000 : 64'hB400;
    localparam logic [DW-1:0] TAPS = DW'(TAPS64);

    logic [DW-1:0] gen_q, gen_d;          // word currently presented on the bus
    logic [DW-1:0] chk_lfsr_q, chk_lfsr_d; // expectation for the next read ack
    logic [DW-1:0] seed_eff;

    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // An all-zero state would lock the LFSR.
    assign seed_eff     = (seed == '0) ? '1 : seed;
    assign exp_word     = chk_lfsr_q;
    assign m_wb_dat_m2s = gen_q;
`else
    assign exp_word     = DW'(chk_idx_q) ^ seed_q;
    assign m_wb_dat_m2s = DW'(idx_q) ^ seed_q;
`endif

    // Reset release is re-timed so the first start is seen two edges after aresetn rises.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign start_ok = start & rst_sync_q[1];
    assign issuing  = (state_q == WRITE) || (state_q == READ);
    assign accept   = m_wb_stb & ~m_wb_stall;
    // An ack with nothing in flight is spurious and must not disturb the count or the checker.
    assign ack_vld  = m_wb_ack & (outst_q != 4'd0);
    // Write acks are all drained before READ, so any valid ack here belongs to a read.
    assign rd_ack   = ack_vld & ((state_q == READ) || (state_q == WAIT_RD));
    assign last_acc = accept & (idx_q == LAST_IDX);

    assign m_wb_stb       = issuing && (outst_q != MAX_OUT);
    assign m_wb_cyc       = cyc_q;
    assign m_wb_we        = (state_q == WRITE);
    assign m_wb_sel       = '1;
    assign m_wb_addr      = addr_q;
    assign busy           = issuing || (state_q == WAIT_WR) || (state_q == WAIT_RD);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == 32'd0);
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        outst_d     = outst_q;
        seed_d      = seed_q;
        chk_idx_d   = chk_idx_q;
        err_d       = err_q;
        first_err_d = first_err_q;
`ifdef WB_MEM_TESTER_LFSR_EN
        gen_d       = gen_q;
        chk_lfsr_d  = chk_lfsr_q;
`endif

        // Accept and ack on the same edge cancel out.
        if (accept && !ack_vld) begin
            outst_d = outst_q + 4'd1;
        end else if (!accept && ack_vld) begin
            outst_d = outst_q - 4'd1;
        end

        if (accept) begin
            addr_d = addr_q + ADDR_BITS'(1);
            idx_d  = idx_q + ADDR_BITS'(1);
`ifdef WB_MEM_TESTER_LFSR_EN
            gen_d  = lfsr_step(gen_q);
`endif
        end

        if (rd_ack) begin
            chk_idx_d  = chk_idx_q + ADDR_BITS'(1);
`ifdef WB_MEM_TESTER_LFSR_EN
            chk_lfsr_d = lfsr_step(chk_lfsr_q);
`endif
            if (m_wb_dat_s2m != exp_word) begin
                if (err_q != '1) begin
                    err_d = err_q + 32'd1;
                end
                if (err_q == 32'd0) begin
                    first_err_d = BASE + chk_idx_q;
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d     = WRITE;
                    cyc_d       = 1'b1;
                    addr_d      = BASE;
                    idx_d       = '0;
                    chk_idx_d   = '0;
                    err_d       = 32'd0;
                    first_err_d = '0;
`ifdef WB_MEM_TESTER_LFSR_EN
                    seed_d      = seed_eff;
                    gen_d       = seed_eff;
                    chk_lfsr_d  = seed_eff;
`else
                    seed_d      = seed;
`endif
                end
            end
            WRITE: begin
                if (last_acc) begin
                    state_d = WAIT_WR;
                    addr_d  = BASE;
                    idx_d   = '0;
`ifdef WB_MEM_TESTER_LFSR_EN
                    gen_d   = seed_q;
`endif
                end
            end
            WAIT_WR: begin
                if (outst_q == 4'd0) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (last_acc) begin
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (outst_q == 4'd0) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            addr_q      <= '0;
            idx_q       <= '0;
            outst_q     <= 4'd0;
            seed_q      <= '0;
            chk_idx_q   <= '0;
            err_q       <= 32'd0;
            first_err_q <= '0;
`ifdef WB_MEM_TESTER_LFSR_EN
            gen_q       <= '0;
            chk_lfsr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            outst_q     <= outst_d;
            seed_q      <= seed_d;
            chk_idx_q   <= chk_idx_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
`ifdef WB_MEM_TESTER_LFSR_EN
            gen_q       <= gen_d;
            chk_lfsr_q  <= chk_lfsr_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_mem_tester.sv
// tb_wb_mem_tester: drives wb_mem_tester against a pipelined Wishbone memory model with configurable
//   ack latency, random stall and spurious acks; predicts every request, the error count and the final status.
module tb_wb_mem_tester;

    localparam int AW   = 8;
    localparam int DB   = 2;
    localparam int DW   = 16;
    localparam int N    = 8;
    localparam int BASE = 254;
    localparam int MAXO = 4;

    logic          clk;
    logic          aresetn;
    logic          start;
    logic [DW-1:0] seed;
    logic          busy, done, pass;
    logic [31:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] m_wb_addr;
    logic [DW-1:0] m_wb_dat_m2s;
    logic [DW-1:0] m_wb_dat_s2m;
    logic          m_wb_we;
    logic [DB-1:0] m_wb_sel;
    logic          m_wb_stb, m_wb_cyc, m_wb_ack, m_wb_stall;

    wb_mem_tester #(
        .ADDR_BITS(AW), .DATA_BYTES(DB), .NUM_WORDS(N),
        .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .aresetn(aresetn), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr),
        .m_wb_addr(m_wb_addr), .m_wb_dat_m2s(m_wb_dat_m2s), .m_wb_dat_s2m(m_wb_dat_s2m),
        .m_wb_we(m_wb_we), .m_wb_sel(m_wb_sel), .m_wb_stb(m_wb_stb), .m_wb_cyc(m_wb_cyc),
        .m_wb_ack(m_wb_ack), .m_wb_stall(m_wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory / reference model state ----------------
    typedef struct {
        int            due;
        bit            we;
        logic [DW-1:0] dat;
    } pend_t;

    pend_t         pend[$];
    logic [DW-1:0] mem[256];
    logic [DW-1:0] cap_wdat[$];
    logic [AW-1:0] cap_addr[$];
    logic [DW-1:0] exp_seed;
    int            lat       = 1;
    int            stall_pct = 0;
    bit            spur_en   = 0;
    bit            fault_en  = 0;
    logic [AW-1:0] fault_addr;
    int            acc_cnt, wr_ack_cnt, rd_ack_cnt, outst, peak_out, cyc_now;
    bit            prev_stall, cyc_on;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_dat;
    logic          prev_we;

    function automatic logic [AW-1:0] word_addr(input int i);
        return AW'(BASE + i);
    endfunction

    function automatic logic [DW-1:0] pattern(input int i);
        return DW'(i) ^ exp_seed;
    endfunction

    // Memory slave + per-cycle compare. Inputs set here hold across the next rising edge;
    // a request is accepted on that edge when stb is high and the stall just chosen is low.
    initial begin
        int            k, wr_before;
        logic [DW-1:0] rd;
        m_wb_ack     = 1'b0;
        m_wb_stall   = 1'b0;
        m_wb_dat_s2m = '0;
        cyc_now      = 0;
        outst        = 0;
        prev_stall   = 0;
        cyc_on       = 0;
        forever begin
            @(negedge clk);
            cyc_now++;
            if (!aresetn) begin
                pend.delete();
                outst      = 0;
                m_wb_ack   = 1'b0;
                m_wb_stall = 1'b0;
                prev_stall = 0;
                cyc_on     = 0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {m_wb_stb, m_wb_we, m_wb_addr, m_wb_dat_m2s},
                          {1'b1, prev_we, prev_addr, prev_dat});
                if (m_wb_cyc) cyc_on = 1;
                if (done) begin
                    check("bus_idle_in_done", {m_wb_cyc, m_wb_stb}, 2'b00);
                    cyc_on = 0;
                end else if (cyc_on) begin
                    check("cyc_held", m_wb_cyc, 1'b1);
                end

                wr_before  = wr_ack_cnt;
                m_wb_stall = ($urandom_range(0, 99) < stall_pct);
                if (pend.size() > 0 && pend[0].due <= cyc_now) begin
                    m_wb_ack     = 1'b1;
                    m_wb_dat_s2m = pend[0].dat;
                    if (pend[0].we) wr_ack_cnt++;
                    else            rd_ack_cnt++;
                    void'(pend.pop_front());
                    outst--;
                end else if (spur_en && pend.size() == 0) begin
                    m_wb_ack     = 1'b1;
                    m_wb_dat_s2m = DW'($urandom);
                end else begin
                    m_wb_ack     = 1'b0;
                    m_wb_dat_s2m = DW'($urandom);
                end

                if (m_wb_stb && !m_wb_stall) begin
                    k = acc_cnt;
                    acc_cnt++;
                    if (k < N) begin
                        check("wr_req", {m_wb_we, m_wb_sel, m_wb_addr, m_wb_dat_m2s},
                              {1'b1, 2'b11, word_addr(k), pattern(k)});
                        mem[m_wb_addr] = m_wb_dat_m2s;
                        cap_wdat.push_back(m_wb_dat_m2s);
                        cap_addr.push_back(m_wb_addr);
                        pend.push_back('{cyc_now + lat, 1'b1, DW'(0)});
                    end else if (k < 2 * N) begin
                        check("rd_req", {m_wb_we, m_wb_sel, m_wb_addr}, {1'b0, 2'b11, word_addr(k - N)});
                        check("rd_after_all_wr_acks", 64'(wr_before), 64'(N));
                        cap_addr.push_back(m_wb_addr);
                        rd = mem[m_wb_addr];
                        if (fault_en && m_wb_addr == fault_addr) rd[0] = ~rd[0];
                        pend.push_back('{cyc_now + lat, 1'b0, rd});
                    end else begin
                        check("req_count", 64'(k), 64'(2 * N - 1));
                    end
                    outst++;
                    if (outst > peak_out) peak_out = outst;
                end
                check("outstanding_le_max", 64'(outst <= MAXO), 64'(1));

                prev_stall = m_wb_stb && m_wb_stall;
                prev_addr  = m_wb_addr;
                prev_dat   = m_wb_dat_m2s;
                prev_we    = m_wb_we;
            end
        end
    end

    // ---------------- run control ----------------
    task automatic start_run(input logic [DW-1:0] s);
        exp_seed   = s;
        seed       = s;
        acc_cnt    = 0;
        wr_ack_cnt = 0;
        rd_ack_cnt = 0;
        peak_out   = 0;
        cap_wdat.delete();
        cap_addr.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed  = ~s;
        check("start_busy_cyc_stb", {busy, m_wb_cyc, m_wb_stb, done}, 4'b1110);
    endtask

    task automatic finish_run(input int exp_err);
        for (int c = 0; c < 4000 && !done; c++) @(negedge clk);
        check("done", done, 1'b1);
        check("busy_clear", busy, 1'b0);
        check("pass", pass, exp_err == 0);
        check("err_count", err_count, 64'(exp_err));
        check("first_err_addr", first_err_addr, (exp_err != 0) ? fault_addr : AW'(0));
        check("accepts", 64'(acc_cnt), 64'(2 * N));
        check("wr_acks", 64'(wr_ack_cnt), 64'(N));
        check("rd_acks", 64'(rd_ack_cnt), 64'(N));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] lit_w [3];
        logic [AW-1:0] lit_a [4];
        lit_w = '{16'h00FF, 16'h00FE, 16'h00FD};
        lit_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        fault_addr = word_addr(3);
        aresetn = 1'b1;
        start   = 1'b0;
        seed    = '0;
        #3 aresetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", {busy, done, pass, err_count, first_err_addr}, '0);
        check("rst_bus", {m_wb_stb, m_wb_cyc, m_wb_we, m_wb_addr, m_wb_dat_m2s}, '0);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);

        // Zero-wait memory, seed 00FF: pattern counts down from 00FF, addresses wrap past FF.
        lat = 1; stall_pct = 0;
        start_run(16'h00FF);
        finish_run(0);
        for (int i = 0; i < 3; i++) check("lit_wdat", cap_wdat[i], lit_w[i]);
        for (int i = 0; i < 4; i++) check("lit_addr", cap_addr[i], lit_a[i]);
        check("lit_rd_addr_wrap", cap_addr[N + 2], 8'h00);
        check("lit_accepts", 64'(acc_cnt), 64'd16);
        check("lit_pass", {done, pass, err_count}, {2'b11, 32'd0});

        // Bit0 flipped on read of word BASE+3 -> one error at address 01.
        fault_en = 1;
        start_run(DW'($urandom));
        finish_run(1);
        check("lit_first_err", first_err_addr, 8'h01);
        fault_en = 0;

        // Long ack latency saturates the in-flight window.
        lat = 10;
        start_run(DW'($urandom));
        finish_run(0);
        check("lit_peak_outstanding", 64'(peak_out), 64'd4);

        // Random stall, spurious acks, start pulsed while busy (must be ignored).
        lat = 2; stall_pct = 50; spur_en = 1;
        start_run(16'hA5C3);
        repeat (3) @(negedge clk);
        seed  = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_poke", busy, 1'b1);
        finish_run(0);
        spur_en = 0; stall_pct = 0;

        // Reset in the middle of the read phase.
        lat = 1;
        start_run(16'h3C3C);
        for (int c = 0; c < 500 && acc_cnt <= N; c++) @(negedge clk);
        @(negedge clk);
        check("stb_before_reset", {m_wb_stb, m_wb_we}, 2'b10);
        #2 aresetn = 1'b0;
        #1;
        check("rst_mid_bus", {m_wb_stb, m_wb_cyc, m_wb_we, m_wb_addr, m_wb_dat_m2s}, '0);
        check("rst_mid_status", {busy, done, pass, err_count, first_err_addr}, '0);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);
        start_run(16'h0F0F);
        finish_run(0);

        // Randomised configurations.
        for (int r = 0; r < 4; r++) begin
            lat       = int'($urandom_range(1, 6));
            stall_pct = int'($urandom_range(0, 60));
            spur_en   = $urandom_range(0, 1) == 1;
            fault_en  = $urandom_range(0, 1) == 1;
            start_run(DW'($urandom));
            finish_run(fault_en ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_mem_tester.md
WB_MEM_TESTER -- requirements
Module: wb_mem_tester

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 23, meaning Wishbone word-address width.
REQ-002 SHALL have parameter DATA_BYTES, default 2, meaning data width in bytes (DW = DATA_BYTES*8).
REQ-003 SHALL have parameter NUM_WORDS, default 1024, meaning words tested (1..2^ADDR_BITS).
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning first word address tested.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, meaning max accepted-but-unacked requests (1..15).
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; aresetn  in  1  async active-low reset.
REQ-007 SHALL have ports: start in 1 run pulse; seed in DW pattern seed; busy out 1; done out 1 sticky completion; pass out 1 zero errors; err_count out 32 mismatches; first_err_addr out ADDR_BITS.
REQ-008 SHALL have pipelined Wishbone master ports: m_wb_addr out ADDR_BITS; m_wb_dat_m2s out DW; m_wb_dat_s2m in DW; m_wb_we out 1; m_wb_sel out DATA_BYTES; m_wb_stb out 1; m_wb_cyc out 1; m_wb_ack in 1; m_wb_stall in 1.

Function
REQ-009 SHALL implement states IDLE, WRITE, WAIT_WR, READ, WAIT_RD, DONE.
REQ-010 SHALL, in IDLE or DONE, on start=1 at a rising edge: latch seed, clear err_count/pass/done/first_err_addr, enter WRITE; stb/cyc high the next cycle.
REQ-011 SHALL ignore start while busy; busy=1 in WRITE, WAIT_WR, READ, WAIT_RD.
REQ-012 SHALL count a request accepted on a cycle with stb=1 and stall=0; addr/dat/we SHALL hold while stalled.
REQ-013 SHALL issue word i at m_wb_addr = (BASE_ADDR + i) mod 2^ADDR_BITS, i = 0..NUM_WORDS-1 in order; m_wb_sel all ones.
REQ-014 SHALL deassert stb when outstanding = MAX_OUTSTANDING; accept and ack in same cycle leave outstanding unchanged.
REQ-015 SHALL ignore m_wb_ack when outstanding = 0.
REQ-016 SHALL go WRITE->WAIT_WR after last write accepted, WAIT_WR->READ when outstanding = 0 (no read issued before all write acks).
REQ-017 SHALL go READ->WAIT_RD after last read accepted, WAIT_RD->DONE when outstanding = 0.
REQ-018 SHALL hold cyc=1 continuously from WRITE entry until DONE entry; stb=0 outside WRITE/READ.
REQ-019 SHALL compare read data in ack order against expected pattern word k (k = k-th read ack).
REQ-020 SHALL increment err_count per mismatch, saturating at 2^32-1; first_err_addr = address of first mismatch.
REQ-021 SHALL, in DONE, assert done=1 and pass=(err_count==0), held until next start.
REQ-022 SHALL, without the macro, use pattern word i = (i mod 2^DW) XOR seed.

Reset
REQ-023 SHALL, on aresetn=0, immediately force IDLE, stb=0, cyc=0, we=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, addr=0, dat_m2s=0, outstanding=0, including mid-transaction.
REQ-024 SHALL release reset synchronously inside the block (first start honoured 2 cycles after deassertion).

Configuration
REQ-025 SHALL, with WB_MEM_TESTER_LFSR_EN defined, use a maximal-length Galois LFSR of width DW (seed 0 replaced by all ones), word 0 = seed, advanced once per word; independent checker LFSR regenerates read expectations.
REQ-026 SHALL, without WB_MEM_TESTER_LFSR_EN, contain no LFSR logic and use REQ-022.

Verification
REQ-027 SHALL cover: NUM_WORDS=8, seed=16'h00FF, zero-wait ideal memory, stall=0 -> writes 00FF,00FE,00FD,..., 16 accepts, done=1, pass=1, err_count=0.
REQ-028 SHALL cover: memory forcing bit0 of word at BASE_ADDR+3 -> err_count=1, first_err_addr=BASE_ADDR+3, pass=0.
REQ-029 SHALL cover: ack latency 10 cycles, MAX_OUTSTANDING=4 -> never more than 4 unacked; no read before 8th write ack.
REQ-030 SHALL cover: random stall 50% -> addr/dat stable while stalled; pass=1.
REQ-031 SHALL cover: aresetn low during READ -> stb/cyc=0 same cycle; start after release -> full pass.
REQ-032 SHALL cover: BASE_ADDR=2^ADDR_BITS-2, NUM_WORDS=4 -> addresses ...FE, ...FF, 0, 1; start pulsed while busy -> ignored.
